// File: rtl/scan_ckpt_ctrl.sv
// Checkpoint sequencer: pauses the emulated DUT and streams its FF and RAM
// scan chains out (dump) or in (load), one 64-bit word per beat.
module scan_ckpt_ctrl #(
  parameter int FF_WORDS   = 4,
  parameter int MEM_WORDS  = 8,
  parameter int RAM_WARMUP = 2,
  parameter int RAM_TAIL   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_load,
  output logic        busy,
  output logic        done,
  output logic        pause,
  output logic        ff_se,
  output logic        ff_dir,
  output logic [63:0] ff_sdi,
  input  logic [63:0] ff_sdo,
  output logic        ram_se,
  output logic        ram_sd,
  output logic [63:0] ram_sdi,
  input  logic [63:0] ram_sdo,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data
);

  localparam int M1 =
    (FF_WORDS > MEM_WORDS) ? FF_WORDS : MEM_WORDS;
  localparam int M2 =
    (RAM_WARMUP > RAM_TAIL) ? RAM_WARMUP : RAM_TAIL;
  // the warm-up and tail phases reuse the word counter
  localparam int MX = (M1 > M2) ? M1 : M2;
  localparam int CW = $clog2(MX + 1);

  localparam logic [CW-1:0] FF_LAST   = CW'(FF_WORDS - 1);
  localparam logic [CW-1:0] MEM_LAST  = CW'(MEM_WORDS - 1);
  localparam logic [CW-1:0] WARM_LAST = CW'(RAM_WARMUP - 1);
  localparam logic [CW-1:0] TAIL_LAST = CW'(RAM_TAIL - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PAUSE,
    S_FF,
    S_WARM,
    S_RAM,
    S_TAIL,
    S_FLUSH
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;
  logic          pause_q;
  logic          done_q;
  logic          beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      pause_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      pause_q <= (state_d != S_IDLE);
      done_q  <= (state_q == S_FLUSH);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    beat      = 1'b0;
    cmd_ready = 1'b0;
    ff_se     = 1'b0;
    ram_se    = 1'b0;
    out_valid = 1'b0;
    in_ready  = 1'b0;
    out_data  = '0;
    ff_sdi    = '0;
    ram_sdi   = '0;
    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          mode_d  = cmd_load;
          cnt_d   = '0;
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: state_d = S_FF;
      S_FF: begin
        if (mode_q) begin
          in_ready = 1'b1;
          ff_sdi   = in_data;
          ff_se    = in_valid;
          beat     = in_valid;
        end else begin
          out_valid = 1'b1;
          out_data  = ff_sdo;
          ff_se     = out_ready;
          beat      = out_ready;
        end
        if (beat) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == FF_LAST) begin
            cnt_d   = '0;
            state_d = mode_q ? S_RAM : S_WARM;
          end
        end
      end
      S_WARM: begin
        ram_se = 1'b1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == WARM_LAST) begin
          cnt_d   = '0;
          state_d = S_RAM;
        end
      end
      S_RAM: begin
        if (mode_q) begin
          in_ready = 1'b1;
          ram_sdi  = in_data;
          ram_se   = in_valid;
          beat     = in_valid;
        end else begin
          out_valid = 1'b1;
          out_data  = ram_sdo;
          ram_se    = out_ready;
          beat      = out_ready;
        end
        if (beat) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == MEM_LAST) begin
            cnt_d   = '0;
            state_d = mode_q ? S_TAIL : S_FLUSH;
          end
        end
      end
      S_TAIL: begin
        ram_se = 1'b1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == TAIL_LAST) begin
          cnt_d   = '0;
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign pause  = pause_q;
  assign ff_dir = mode_q;
  assign ram_sd = mode_q;

endmodule

// File: tb/tb_scan_ckpt_ctrl.sv
// Directed bench for scan_ckpt_ctrl with a behavioural FF ring and
// a RAM chain model (2-deep read pipe, 1-deep write pipe).
module tb_scan_ckpt_ctrl;

  localparam int FW = 3;
  localparam int MW = 4;
  localparam int RW = 2;
  localparam int RT = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_load = 1'b0;
  logic        busy;
  logic        done;
  logic        pause;
  logic        ff_se;
  logic        ff_dir;
  logic [63:0] ff_sdi;
  logic [63:0] ff_sdo;
  logic        ram_se;
  logic        ram_sd;
  logic [63:0] ram_sdi;
  logic [63:0] ram_sdo;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;

  always #5 clk = ~clk;

  scan_ckpt_ctrl #(
    .FF_WORDS(FW), .MEM_WORDS(MW),
    .RAM_WARMUP(RW), .RAM_TAIL(RT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_load(cmd_load), .busy(busy), .done(done),
    .pause(pause),
    .ff_se(ff_se), .ff_dir(ff_dir),
    .ff_sdi(ff_sdi), .ff_sdo(ff_sdo),
    .ram_se(ram_se), .ram_sd(ram_sd),
    .ram_sdi(ram_sdi), .ram_sdo(ram_sdo),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data)
  );

  logic [63:0] ffc[FW];
  logic [63:0] mem[MW];
  logic [63:0] p0, p1, lp;
  int          rp, lcnt;

  assign ff_sdo  = ffc[0];
  assign ram_sdo = p1;

  logic [63:0] dq[$];
  logic [63:0] lq[$];
  logic [63:0] saved[FW+MW];
  logic [63:0] ld_words[FW+MW];
  int n_vec = 0, n_err = 0;
  int cyc = 0, np, nstall, se_bad, ntail, nin, nhs, ndone = 0;
  int t_hs, t_hs1, t_done, k;
  bit tog = 1'b0;

  function automatic logic [63:0] exp_w(int i);
    if (i < FW) return 64'hAAAA_0000_0000_0000 | 64'(i);
    return 64'hBBBB_0000_0000_0000 | 64'(i - FW);
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    dq.delete();
    lq.delete();
    np = 0; nstall = 0; se_bad = 0;
    ntail = 0; nin = 0; nhs = 0;
    in_data = ld_words[0];
  endtask

  // One clock cycle: observe at negedge, step chain models at posedge.
  task automatic cyc_run();
    logic do_ff, fdir, do_ram, rdir, pz;
    logic [63:0] fsdi, rsdi, t;
    @(negedge clk);
    if (cmd_valid && cmd_ready) begin
      if (nhs == 0) t_hs1 = cyc;
      t_hs = cyc;
      nhs++;
    end
    if (done) begin ndone++; t_done = cyc; end
    if (pause) np++;
    if (out_valid && ((ff_se | ram_se) !== out_ready))
      se_bad++;
    if (out_valid && !out_ready) nstall++;
    if (out_valid && out_ready) dq.push_back(out_data);
    if (ff_se && ff_dir) lq.push_back(ff_sdi);
    if (ram_se && ram_sd && in_ready) lq.push_back(ram_sdi);
    if (ram_se && ram_sd && !in_ready) ntail++;
    if (in_valid && in_ready) nin++;
    do_ff = ff_se; fdir = ff_dir; fsdi = ff_sdi;
    do_ram = ram_se; rdir = ram_sd; rsdi = ram_sdi;
    pz = pause;
    @(posedge clk);
    cyc++;
    if (do_ff) begin
      t = ffc[0];
      for (int i = 0; i < FW - 1; i++) ffc[i] = ffc[i+1];
      ffc[FW-1] = fdir ? fsdi : t;
    end
    if (!pz) begin
      rp = 0; lcnt = 0;
    end else if (do_ram) begin
      if (!rdir) begin
        p1 = p0; p0 = mem[rp]; rp = (rp + 1) % MW;
      end else begin
        if (lcnt > 0 && lcnt <= MW) mem[lcnt-1] = lp;
        lp = rsdi;
        lcnt++;
      end
    end
    #1;
    if (tog) out_ready = ~out_ready;
    in_data = (nin < FW + MW) ? ld_words[nin] : '0;
  endtask

  task automatic start(input logic ld);
    cmd_load = ld;
    cmd_valid = 1'b1;
    cyc_run();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n0, j;
    n0 = ndone; j = 0;
    while (ndone == n0 && j < budget) begin
      cyc_run();
      j++;
    end
    chk(tag, 64'(ndone > n0), 64'd1);
  endtask

  initial begin
    for (int i = 0; i < FW; i++) ffc[i] = exp_w(i);
    for (int i = 0; i < MW; i++) mem[i] = exp_w(FW + i);
    for (int i = 0; i < FW + MW; i++) ld_words[i] = '0;
    p0 = '0; p1 = '0; lp = '0; rp = 0; lcnt = 0;
    t_hs = 0; t_hs1 = 0; t_done = 0; k = 0;
    clr();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl",
        64'({cmd_ready, busy, done, pause, ff_se, ff_dir,
             ram_se, ram_sd, out_valid, in_ready}),
        64'b10_0000_0000);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_ff_sdi", ff_sdi, 64'd0);
    chk("rst_ram_sdi", ram_sdi, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // dump, no stall
    clr();
    out_ready = 1'b1;
    start(1'b0);
    wait_done("dump_timeout", 40);
    chk("dump_beats", 64'(dq.size()), 64'd7);
    for (int i = 0; i < dq.size() && i < FW + MW; i++) begin
      chk($sformatf("dump_w%0d", i), dq[i], exp_w(i));
      saved[i] = dq[i];
    end
    chk("dump_pause_cyc", 64'(np), 64'd11);
    chk("dump_done_lat", 64'(t_done - t_hs), 64'd12);
    chk("dump_dir", 64'({ff_dir, ram_sd}), 64'd0);

    // dump with out_ready toggling 0,1,0,1 from the handshake
    clr();
    out_ready = 1'b0;
    tog = 1'b1;
    start(1'b0);
    wait_done("tog_timeout", 60);
    tog = 1'b0;
    chk("tog_beats", 64'(dq.size()), 64'd7);
    for (int i = 0; i < dq.size() && i < FW + MW; i++)
      chk($sformatf("tog_w%0d", i), dq[i], exp_w(i));
    chk("tog_se_follow", 64'(se_bad), 64'd0);
    chk("tog_stalls", 64'(nstall), 64'd7);
    chk("tog_done_lat", 64'(t_done - t_hs), 64'd19);
    chk("tog_pause_cyc", 64'(np), 64'd18);

    // load 0x1000+i
    for (int i = 0; i < FW + MW; i++)
      ld_words[i] = 64'h1000 + 64'(i);
    clr();
    out_ready = 1'b0;
    in_valid = 1'b1;
    start(1'b1);
    wait_done("load_timeout", 40);
    in_valid = 1'b0;
    chk("load_words", 64'(lq.size()), 64'd7);
    for (int i = 0; i < lq.size() && i < FW + MW; i++)
      chk($sformatf("load_w%0d", i), lq[i], 64'h1000 + 64'(i));
    chk("load_tail", 64'(ntail), 64'd1);
    chk("load_pause_cyc", 64'(np), 64'd10);
    chk("load_done_lat", 64'(t_done - t_hs), 64'd11);
    chk("load_dir_hold", 64'({ff_dir, ram_sd}), 64'd3);

    // dump the loaded image back
    clr();
    out_ready = 1'b1;
    start(1'b0);
    wait_done("rt1_timeout", 40);
    chk("rt1_beats", 64'(dq.size()), 64'd7);
    for (int i = 0; i < dq.size() && i < FW + MW; i++)
      chk($sformatf("rt1_w%0d", i), dq[i], 64'h1000 + 64'(i));

    // corrupt, then restore the first dump
    for (int i = 0; i < FW; i++) ffc[i] = 64'hDEAD_0000 + 64'(i);
    for (int i = 0; i < MW; i++) mem[i] = 64'hDEAD_1000 + 64'(i);
    for (int i = 0; i < FW + MW; i++) ld_words[i] = saved[i];
    clr();
    out_ready = 1'b0;
    in_valid = 1'b1;
    start(1'b1);
    wait_done("rt2_timeout", 40);
    in_valid = 1'b0;
    for (int i = 0; i < FW; i++)
      chk($sformatf("rt_ff%0d", i), ffc[i], exp_w(i));
    for (int i = 0; i < MW; i++)
      chk($sformatf("rt_mem%0d", i), mem[i], exp_w(FW + i));

    // cmd_valid held: second start only in the done cycle
    clr();
    out_ready = 1'b1;
    cmd_load = 1'b0;
    cmd_valid = 1'b1;
    k = 0;
    while (nhs < 2 && k < 60) begin
      cyc_run();
      k++;
    end
    cmd_valid = 1'b0;
    wait_done("b2b_timeout", 40);
    chk("b2b_starts", 64'(nhs), 64'd2);
    chk("b2b_gap", 64'(t_hs - t_hs1), 64'd12);
    chk("b2b_done_lat", 64'(t_done - t_hs), 64'd12);
    chk("b2b_beats", 64'(dq.size()), 64'd14);

    // reset during the second RAM beat
    clr();
    out_ready = 1'b1;
    start(1'b0);
    k = 0;
    while (dq.size() < FW + 1 && k < 30) begin
      cyc_run();
      k++;
    end
    chk("abort_reach", 64'(dq.size()), 64'(FW + 1));
    chk("abort_pre_ov", 64'({out_valid, ram_se}), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("abort_ctl",
        64'({pause, busy, out_valid, ff_se, ram_se}), 64'd0);
    chk("abort_cmd_ready", 64'(cmd_ready), 64'd1);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_idle", 64'({cmd_ready, busy, done}), 64'd4);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/scan_ckpt_ctrl.md
# scan_ckpt_ctrl

Checkpoint sequencer for the emulated DUT's scan chains. It accepts a dump or load command and sequences the whole operation:
- pauses the DUT clocks;
- shifts the flip-flop scan chain, then the RAM scan chain, one 64-bit word per beat over valid/ready streams;
- resumes the DUT.

It sits between the host/checkpoint DMA side and the EMU_DUT scan ports, replacing hand-sequenced pause/scan timing.

## Interface
Parameters:
- FF_WORDS, 4, 64-bit words in the FF chain (≥1)
- MEM_WORDS, 8, 64-bit words in the RAM chain (≥1)
- RAM_WARMUP, 2, RAM-chain pipeline cycles before the first valid dump word (≥1)
- RAM_TAIL, 1, extra shift cycles after the last load word (≥1)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high in IDLE only
- cmd_load  in  1  0 = dump, 1 = load; sampled on cmd handshake
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse on return to IDLE
- pause  out  1  DUT clock gate disable, to both ClockGate instances
- ff_se  out  1  FF chain scan enable
- ff_dir  out  1  FF chain direction; 1 selects ff_sdi (load); 0 means rotate sdo→di
- ff_sdi  out  64  FF load data
- ff_sdo  in  64  FF chain output
- ram_se  out  1  RAM chain scan enable
- ram_sd  out  1  RAM scan direction; 1 = load
- ram_sdi  out  64  RAM load data
- ram_sdo  in  64  RAM chain output
- out_valid, out_ready, out_data[63:0]  out/in/out  dump stream
- in_valid, in_ready, in_data[63:0]  in/out/in  load stream

## Operation
- **States:** IDLE, PAUSE, FF, RAM_WARM, RAM, RAM_TAIL, FLUSH.
- **IDLE:**
  - cmd_ready=1.
  - On handshake, latch `mode` = cmd_load and go to PAUSE.
  - Clear the word counter (width $clog2(max(FF_WORDS, MEM_WORDS)+1)).
- **PAUSE:** one settle cycle, then go to FF.
- **FF, dump:**
  - out_valid=1, out_data=ff_sdo, ff_se=out_ready.
  - Each beat increments the counter.
  - After beat FF_WORDS: clear the counter and go to RAM_WARM.
- **FF, load:**
  - in_ready=1, ff_sdi=in_data, ff_se=in_valid.
  - After FF_WORDS beats go to RAM (RAM_WARM is skipped).
- **RAM_WARM (dump only):**
  - ram_se=1 for RAM_WARMUP cycles, counted with the same counter.
  - No out_valid.
  - Then go to RAM.
- **RAM, dump:**
  - out_valid=1, out_data=ram_sdo, ram_se=out_ready.
  - Deasserting ram_se freezes the RAM chain, because its clock is gated.
  - After MEM_WORDS beats go to FLUSH.
- **RAM, load:**
  - in_ready=1, ram_sdi=in_data, ram_se=in_valid.
  - After MEM_WORDS beats go to RAM_TAIL.
- **RAM_TAIL (load only):** ram_se=1, in_ready=0 for RAM_TAIL cycles, then go to FLUSH.
- **FLUSH:** both se=0, pause=1 for one cycle, then go to IDLE with done=1 for one cycle.
- **Register assignments:**
  - pause = (state ≠ IDLE), registered.
  - ff_dir = mode and ram_sd = mode, registered; they hold their value in IDLE.
  - ff_se, ram_se, out_valid, in_ready and the data muxes are combinational from state, mode and the peer handshake.
- **Outside their phase:** ff_se, ram_se, out_valid and in_ready are 0.
- **Data outputs:** ff_sdi and ram_sdi are 0 outside load phases; out_data is 0 outside dump phases.
- **Ignored commands:** cmd_valid while busy is ignored (cmd_ready=0).

## Timing
- **Reset:**
  - rst_n low resets all registers asynchronously: state=IDLE, counter=0, mode=0, done=0.
  - All outputs read 0 except cmd_ready=1.
  - Reset mid-operation aborts immediately; pause drops in the same cycle, and chain contents are undefined.
- **Dump latency** (handshake in cycle t, out_ready constantly 1):

  | Cycles | State / activity |
  |---|---|
  | t+1 | PAUSE |
  | t+2 … t+1+FF_WORDS | FF beats |
  | next RAM_WARMUP cycles | RAM_WARM |
  | next MEM_WORDS cycles | RAM beats |
  | 1 cycle | FLUSH |
  | next cycle | IDLE with done=1 |

  pause is high for 2+FF_WORDS+RAM_WARMUP+MEM_WORDS cycles.
- **Load latency:** same sequence without RAM_WARM, plus RAM_TAIL. pause is high for 2+FF_WORDS+MEM_WORDS+RAM_TAIL cycles.
- **Stalls:** each stall cycle (ready or valid low) adds exactly one cycle. Chain state is unchanged while its se=0.
- **Phase boundaries:**
  - The last FF beat and the first RAM-phase cycle are never merged.
  - A beat completes only on valid&&ready at the rising edge.
- **cmd_valid in the done cycle:** accepted; the new command starts the next cycle.

## Test plan
- **Dump with FF_WORDS=3, MEM_WORDS=4, RAM_WARMUP=2 and out_ready=1:**
  - Expect 7 out beats.
  - The first 3 equal ff_sdo, the last 4 equal ram_sdo.
  - pause is high exactly 11 cycles; done pulses at t+12.
- **Dump with out_ready toggling 1,0,1,0…:**
  - ff_se and ram_se follow out_ready during beat phases.
  - The beat sequence matches the no-stall run word for word.
  - Completion is delayed by the stall count.
- **Load with in_data=0x1000+i and in_valid=1:**
  - ff_sdi carries 0x1000..0x1002 with ff_dir=1.
  - ram_sdi carries 0x1003..0x1006 with ram_sd=1.
  - ram_se stays high 1 extra cycle after the last beat.
  - pause is high 10 cycles.
- **Round trip against the DUT:** dump, corrupt the memories, load the saved words. All mem1/mem2/mem3 words and the rdata registers return the pre-dump values.
- **cmd_valid held high during busy:** no second start occurs. With back-to-back commands, the second starts the cycle after done.
- **rst_n low at the second RAM beat:** pause, se, busy and out_valid drop to 0 immediately; after release, cmd_ready=1.
